ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage; consumes the decoded op/operands latched from decode by the ID/EX register.
//  Logic, shift and HI/LO-move ops resolve combinationally in one cycle.
//  DIV/DIVU run on an iterative radix-2 divider (one quotient bit per cycle) and hold the
//  pipeline through stallreq_o. HI/LO reads forward from the mem/wb stages.
//  Results go to the EX/MEM register and back to decode as the ex_* forwarding inputs.
// PARAMETERS
//  DIV_BITS  32  dividend/divisor width; also the divider iteration count
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   synchronous reset, active-high (`RstEnable)
//  aluop_i       in   8   `AluOpBus operation; adds `EXE_DIV_OP / `EXE_DIVU_OP to defines.v
//  alusel_i      in   3   `AluSelBus result class (LOGIC/SHIFT/MOVE/NOP)
//  reg1_i        in   32  operand 1 (rs, or shamt in imm for SLL/SRL/SRA)
//  reg2_i        in   32  operand 2 (rt or immediate)
//  wd_i          in   5   destination GPR address
//  wreg_i        in   1   GPR write enable from decode
//  hi_i/lo_i     in   32  architectural HI/LO
//  mem_whilo_i   in   1   mem-stage HI/LO write pending; mem_hi_i/mem_lo_i in 32 each
//  wb_whilo_i    in   1   wb-stage HI/LO write pending; wb_hi_i/wb_lo_i in 32 each
//  div_cancel_i  in   1   abort in-flight division (pipeline flush)
//  wd_o          out  5   = wd_i
//  wreg_o        out  1   = wreg_i
//  wdata_o       out  32  GPR write data
//  whilo_o       out  1   HI/LO write enable
//  hi_o/lo_o     out  32  HI/LO write data
//  stallreq_o    out  1   hold IF/ID/EX; ID/EX keeps current inputs stable while high
// BEHAVIOUR
//  - rst high: every output 0; divider FSM goes to IDLE; internal registers cleared.
//  - HI/LO forwarding: mem_* (if mem_whilo_i) > wb_* (if wb_whilo_i) > hi_i/lo_i.
//  - LOGIC: OR/AND/XOR/NOR of reg1_i, reg2_i.
//  - SHIFT: reg2_i shifted by reg1_i[4:0]. SRA sign-fills from reg2_i[31].
//  - MOVE ops:
//    - MFHI/MFLO: wdata = forwarded HI/LO.
//    - MOVN/MOVZ: wdata = reg1_i.
//    - MTHI: whilo=1, hi_o=reg1_i, lo_o=fwd LO. MTLO is the mirror case.
//  - alusel NOP or unknown op: wdata_o=0, whilo_o=0.
//  - Divider FSM states: IDLE, DZERO, BUSY, DONE.
//    - IDLE + DIV/DIVU + reg2_i==0 -> DZERO. IDLE + DIV/DIVU + reg2_i!=0 -> BUSY.
//      On this issue cycle: latch |operands| (signed) or raw operands (unsigned);
//      latch result-sign flags; cnt=0.
//    - BUSY: one shift-subtract step per cycle, cnt++. After cnt reaches 31 -> DONE.
//    - DZERO -> DONE, with quotient=0 and remainder=0.
//    - DONE -> IDLE unconditionally. The op still present in DONE never re-issues.
//  - Signed fixup in DONE:
//    - quotient negated if sign(reg1)!=sign(reg2); remainder takes the dividend's sign.
//    - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (32-bit wrap).
//  - stallreq_o:
//    - High in the issue cycle and in all DZERO/BUSY cycles; low in DONE and IDLE.
//    - Non-zero divisor: 33 stall cycles, result in cycle 34. Divide by zero: 2 stalls.
//  - DONE: whilo_o=1, lo_o=quotient, hi_o=remainder.
//  - div_cancel_i high in any state: FSM -> IDLE next edge.
//    stallreq_o and whilo_o forced 0 that same cycle. Cancel beats issue in IDLE.
//  - rst mid-division: same as cancel, plus all outputs 0.
//  - Back-to-back DIVs: second issues from IDLE the cycle after DONE.
// TESTING
//  1 OR reg1=0x0000F0F0 reg2=0x00FF0000 -> wdata_o=0x00FFF0F0 same cycle, stallreq_o=0.
//  2 SRA reg2=0x80000010 reg1=4 -> 0xF8000001; SRL same operands -> 0x08000001.
//  3 MFHI with hi_i=1, wb_hi_i=2 (wb_whilo_i), mem_hi_i=3 (mem_whilo_i) -> 3;
//    drop mem_whilo_i -> 2; drop wb_whilo_i -> 1.
//  4 DIVU 100/7 -> 33 stall cycles then whilo_o=1, lo=14, hi=2;
//    DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  5 DIV x/0 -> stallreq_o high 2 cycles, then whilo_o=1, lo=hi=0;
//    then 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  6 div_cancel_i on BUSY cycle 10 -> stallreq_o=0 that cycle, no whilo_o;
//    next DIVU 9/3 completes lo=3, hi=0; repeat with rst.

Source files
------------

// File: rtl/ex_stage_if.sv
// Execute-stage bus: decoded op/operands and HI/LO forwarding in, GPR and HI/LO results out.
// The slave modport belongs to ex_stage; the master modport belongs to whoever drives ID/EX.
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i;
  logic [31:0] mem_lo_i;
  logic        wb_whilo_i;
  logic [31:0] wb_hi_i;
  logic [31:0] wb_lo_i;
  logic        div_cancel_i;

  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
    input  wb_whilo_i, wb_hi_i, wb_lo_i, div_cancel_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
    output wb_whilo_i, wb_hi_i, wb_lo_i, div_cancel_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/move ops plus an iterative radix-2 divider
// that holds the pipeline through stallreq_o.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | no division in flight; a DIV/DIVU here is the issue cycle
//  S_DZERO | divisor was zero; result forced to 0/0
//  S_BUSY  | one shift-subtract step per cycle, cnt_q = step index
//  S_DONE  | signed fixup applied, HI/LO written, pipeline released
module ex_stage #(
  parameter int DIV_BITS = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  localparam int CW = $clog2(DIV_BITS);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DIV_BITS - 1);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [DIV_BITS-1:0] ZERO     = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DZERO = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  // HI/LO forwarding
  logic [31:0] hi_fwd, lo_fwd;

  always_comb begin
    hi_fwd = bus.hi_i;
    lo_fwd = bus.lo_i;
    if (bus.mem_whilo_i) begin
      hi_fwd = bus.mem_hi_i;
      lo_fwd = bus.mem_lo_i;
    end else if (bus.wb_whilo_i) begin
      hi_fwd = bus.wb_hi_i;
      lo_fwd = bus.wb_lo_i;
    end
  end

  // single-cycle datapath
  logic [31:0] logic_res, shift_res, move_res, alu_wdata;
  logic [31:0] mt_hi, mt_lo;
  logic        mt_we;
  logic [4:0]  shamt;

  assign shamt = bus.reg1_i[4:0];

  always_comb begin
    logic_res = '0;
    case (bus.aluop_i)
      EXE_OR_OP:  logic_res = bus.reg1_i | bus.reg2_i;
      EXE_AND_OP: logic_res = bus.reg1_i & bus.reg2_i;
      EXE_XOR_OP: logic_res = bus.reg1_i ^ bus.reg2_i;
      EXE_NOR_OP: logic_res = ~(bus.reg1_i | bus.reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (bus.aluop_i)
      EXE_SLL_OP: shift_res = bus.reg2_i << shamt;
      EXE_SRL_OP: shift_res = bus.reg2_i >> shamt;
      EXE_SRA_OP: shift_res = $signed(bus.reg2_i) >>> shamt;
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    mt_we    = 1'b0;
    mt_hi    = '0;
    mt_lo    = '0;
    case (bus.aluop_i)
      EXE_MFHI_OP: move_res = hi_fwd;
      EXE_MFLO_OP: move_res = lo_fwd;
      EXE_MOVN_OP,
      EXE_MOVZ_OP: move_res = bus.reg1_i;
      EXE_MTHI_OP: begin
        mt_we = 1'b1;
        mt_hi = bus.reg1_i;
        mt_lo = lo_fwd;
      end
      EXE_MTLO_OP: begin
        mt_we = 1'b1;
        mt_hi = hi_fwd;
        mt_lo = bus.reg1_i;
      end
      default: move_res = '0;
    endcase
  end

  always_comb begin
    alu_wdata = '0;
    case (bus.alusel_i)
      RES_LOGIC: alu_wdata = logic_res;
      RES_SHIFT: alu_wdata = shift_res;
      RES_MOVE:  alu_wdata = move_res;
      default:   alu_wdata = '0;
    endcase
  end

  // divider
  div_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIV_BITS-1:0] quo_q, quo_d;
  logic [DIV_BITS-1:0] rem_q, rem_d;
  logic [DIV_BITS-1:0] dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                div_stall, div_done;

  logic                is_div, is_signed, neg1, neg2;
  logic [DIV_BITS-1:0] op1, op2, abs1, abs2;
  logic [DIV_BITS:0]   partial, diff;
  logic [DIV_BITS-1:0] div_lo, div_hi;

  assign is_div    = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
  assign is_signed = (bus.aluop_i == EXE_DIV_OP);
  assign op1       = bus.reg1_i[DIV_BITS-1:0];
  assign op2       = bus.reg2_i[DIV_BITS-1:0];
  assign neg1      = is_signed & op1[DIV_BITS-1];
  assign neg2      = is_signed & op2[DIV_BITS-1];
  assign abs1      = neg1 ? (ZERO - op1) : op1;
  assign abs2      = neg2 ? (ZERO - op2) : op2;

  // quo_q shifts the dividend out at the top while quotient bits enter at the bottom
  assign partial = {rem_q, quo_q[DIV_BITS-1]};
  assign diff    = partial - {1'b0, dvs_q};

  assign div_lo = qneg_q ? (ZERO - quo_q) : quo_q;
  assign div_hi = rneg_q ? (ZERO - rem_q) : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_stall = 1'b0;
    div_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          div_stall = 1'b1;
          cnt_d     = '0;
          rem_d     = '0;
          if (op2 == ZERO) begin
            state_d = S_DZERO;
            quo_d   = '0;
            dvs_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = S_BUSY;
            quo_d   = abs1;
            dvs_d   = abs2;
            qneg_d  = neg1 ^ neg2;
            rneg_d  = neg1;
          end
        end
      end
      S_DZERO: begin
        div_stall = 1'b1;
        state_d   = S_DONE;
      end
      S_BUSY: begin
        div_stall = 1'b1;
        cnt_d     = cnt_q + CNT_ONE;
        if (!diff[DIV_BITS]) begin
          rem_d = diff[DIV_BITS-1:0];
          quo_d = {quo_q[DIV_BITS-2:0], 1'b1};
        end else begin
          rem_d = partial[DIV_BITS-1:0];
          quo_d = {quo_q[DIV_BITS-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        div_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a flush wins over everything, including a fresh issue from idle
    if (bus.div_cancel_i) begin
      state_d   = S_IDLE;
      div_stall = 1'b0;
      div_done  = 1'b0;
    end
  end

  // output mux
  always_comb begin
    bus.wd_o       = '0;
    bus.wreg_o     = 1'b0;
    bus.wdata_o    = '0;
    bus.whilo_o    = 1'b0;
    bus.hi_o       = '0;
    bus.lo_o       = '0;
    bus.stallreq_o = 1'b0;
    if (!rst) begin
      bus.wd_o       = bus.wd_i;
      bus.wreg_o     = bus.wreg_i;
      bus.wdata_o    = alu_wdata;
      bus.stallreq_o = div_stall;
      if (div_done) begin
        bus.whilo_o = 1'b1;
        bus.hi_o    = div_hi;
        bus.lo_o    = div_lo;
      end else if (mt_we && (bus.alusel_i == RES_MOVE) && !bus.div_cancel_i) begin
        bus.whilo_o = 1'b1;
        bus.hi_o    = mt_hi;
        bus.lo_o    = mt_lo;
      end
    end
  end

endmodule
